// File: rtl/delay_sweep_ctrl.sv
// Calibration sequencer for delay_module: sweeps the delay select, correlates
// ref_in against dly_out at each setting and reports the best-matching setting.
module delay_sweep_ctrl #(
  parameter int unsigned N         = 16,
  parameter int unsigned MAX_DELAY = 40,
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned SETTLE    = 2,
  localparam int unsigned DW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1,
  localparam int unsigned ACC_W    = 2*N + $clog2(WINDOW) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    sample_en_i,
  input  logic signed [N-1:0]     ref_in_i,
  input  logic signed [N-1:0]     dly_out_i,
  output logic [DW-1:0]           dly_number_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DW-1:0]           best_delay_o,
  output logic signed [ACC_W-1:0] best_corr_o
);

  localparam int unsigned SCW = $clog2(SETTLE + 1);
  localparam int unsigned WCW = $clog2(WINDOW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_SETTLE,
    S_ACCUM,
    S_CMP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           dly_number_q, dly_number_d;
  logic [SCW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [WCW-1:0]          win_cnt_q, win_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] run_best_q, run_best_d;
  logic [DW-1:0]           run_idx_q, run_idx_d;
  logic [DW-1:0]           best_delay_q, best_delay_d;
  logic signed [ACC_W-1:0] best_corr_q, best_corr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [2*N-1:0]   prod_c;

  assign prod_c = ref_in_i * dly_out_i;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      dly_number_q <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      run_best_q   <= '0;
      run_idx_q    <= '0;
      best_delay_q <= '0;
      best_corr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dly_number_q <= dly_number_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      run_best_q   <= run_best_d;
      run_idx_q    <= run_idx_d;
      best_delay_q <= best_delay_d;
      best_corr_q  <= best_corr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dly_number_d = dly_number_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    acc_d        = acc_q;
    run_best_d   = run_best_q;
    run_idx_d    = run_idx_q;
    best_delay_d = best_delay_q;
    best_corr_d  = best_corr_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_SET;
          idx_d   = '0;
        end
      end
      S_SET: begin
        dly_number_d = idx_q;
        acc_d        = '0;
        settle_cnt_d = '0;
        win_cnt_d    = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == SCW'(SETTLE - 1)) begin
          state_d = S_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
        end
      end
      S_ACCUM: begin
        if (sample_en_i) begin
          acc_d = acc_q + ACC_W'(prod_c);
          if (win_cnt_q == WCW'(WINDOW - 1)) begin
            state_d = S_CMP;
          end else begin
            win_cnt_d = win_cnt_q + WCW'(1);
          end
        end
      end
      S_CMP: begin
        // Strict compare so a tie keeps the lower setting
        if (idx_q == '0 || acc_q > run_best_q) begin
          run_best_d = acc_q;
          run_idx_d  = idx_q;
        end
        if (idx_q == DW'(MAX_DELAY - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + DW'(1);
          state_d = S_SET;
        end
      end
      S_DONE: begin
        done_d       = 1'b1;
        best_delay_d = run_idx_q;
        best_corr_d  = run_best_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition, including result publication
    if (abort_i && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      done_d       = 1'b0;
      dly_number_d = dly_number_q;
      best_delay_d = best_delay_q;
      best_corr_d  = best_corr_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign dly_number_o = dly_number_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign best_delay_o = best_delay_q;
  assign best_corr_o  = best_corr_q;

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Bench for delay_sweep_ctrl: behavioural delay line, reference correlation model
// and a scoreboard of expected sweep results checked on each done pulse.
module tb_delay_sweep_ctrl;

  localparam int unsigned N     = 16;
  localparam int unsigned MD    = 8;
  localparam int unsigned W     = 16;
  localparam int unsigned ST    = 2;
  localparam int unsigned DW    = 3;
  localparam int unsigned ACC_W = 2*N + $clog2(W) + 1;
  localparam int          SZ    = 1024;

  typedef struct {
    int     bd;
    longint bc;
    int     lat;
    int     s;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    abort;
  logic                    sample_en;
  logic signed [N-1:0]     ref_in;
  logic signed [N-1:0]     dly_out;
  logic [DW-1:0]           dly_number;
  logic                    busy;
  logic                    done;
  logic [DW-1:0]           best_delay;
  logic signed [ACC_W-1:0] best_corr;

  int   cyc = 0;
  int   xs[SZ];
  int   s_base = 0;
  bit   tog = 1'b0;
  bit   zero = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   n_acc = 0;
  exp_t sb[$];

  delay_sweep_ctrl #(.N(N), .MAX_DELAY(MD), .WINDOW(W), .SETTLE(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .sample_en_i  (sample_en),
    .ref_in_i     (ref_in),
    .dly_out_i    (dly_out),
    .dly_number_o (dly_number),
    .busy_o       (busy),
    .done_o       (done),
    .best_delay_o (best_delay),
    .best_corr_o  (best_corr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int xv(input int s, input int c);
    return xs[(((c - s) % SZ) + SZ) % SZ];
  endfunction

  // Delay line model: out is x delayed number+2, ref is x delayed 7
  always @(negedge clk) begin
    sample_en = !tog || (((cyc - s_base) % 2) != 0);
    ref_in    = zero ? '0 : N'(xv(s_base, cyc - 7));
    dly_out   = N'(xv(s_base, cyc - int'(dly_number) - 2));
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference correlation over the sample windows implied by the sweep timing
  task automatic compute_exp(input int s, input bit tg, input bit zr, output exp_t e);
    int     p;
    longint acc;
    p = tg ? 36 : int'(W + ST + 2);
    e.bd = 0;
    e.bc = 0;
    for (int k = 0; k < int'(MD); k++) begin
      acc = 0;
      for (int c = s + k*p + 4; c < s + k*p + p; c++) begin
        if (!tg || ((c - s) % 2 == 1))
          acc += longint'(zr ? 0 : xv(s, c - 7)) * longint'(xv(s, c - k - 2));
      end
      if (k == 0 || acc > e.bc) begin
        e.bd = k;
        e.bc = acc;
      end
    end
    e.lat = 1 + int'(MD) * p;
    e.s   = s;
  endtask

  task automatic launch(input bit tg, input bit zr, input bit push,
                        output int s, output exp_t e);
    @(negedge clk);
    tog    = tg;
    zero   = zr;
    s      = cyc;
    s_base = cyc;
    compute_exp(s, tg, zr, e);
    if (push) begin
      sb.push_back(e);
      n_acc++;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_sweep(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("sweep_timeout", longint'(sb.size()), 0);
    check("busy_after_done", longint'(busy), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dly_number"}, longint'(dly_number), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_best_delay"}, longint'(best_delay), 0);
    check({tag, "_best_corr"}, longint'(best_corr), 0);
  endtask

  // Scoreboard: every done pulse must match the oldest accepted sweep
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("best_delay", longint'(best_delay), longint'(e.bd));
        check("best_corr", longint'(best_corr), e.bc);
        check("done_latency", longint'(cyc - 1 - e.s), longint'(e.lat));
      end
    end
  end

  initial begin : stim
    int   s;
    exp_t e;
    exp_t e_ref;
    for (int i = 0; i < SZ; i++) xs[i] = int'($urandom_range(0, 2000)) - 1000;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Plain sweep, zero reference, toggling sample_en
    launch(1'b0, 1'b0, 1'b1, s, e);
    wait_sweep(400);
    launch(1'b0, 1'b1, 1'b1, s, e);
    wait_sweep(400);
    launch(1'b1, 1'b0, 1'b1, s, e);
    wait_sweep(600);

    // Abort mid-sweep after a completed sweep, then repeat
    launch(1'b0, 1'b0, 1'b1, s, e_ref);
    wait_sweep(400);
    launch(1'b0, 1'b0, 1'b0, s, e);
    while (cyc < s + 70) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_dly_number", longint'(dly_number), 3);
    repeat (250) @(negedge clk);
    check("abort_hold_delay", longint'(best_delay), longint'(e_ref.bd));
    check("abort_hold_corr", longint'(best_corr), e_ref.bc);
    launch(1'b0, 1'b0, 1'b1, s, e);
    wait_sweep(400);

    // Reset mid-SETTLE
    launch(1'b0, 1'b0, 1'b0, s, e);
    while (cyc < s + 2) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    launch(1'b0, 1'b0, 1'b1, s, e);
    wait_sweep(400);

    // start while busy, then start+abort together in IDLE
    launch(1'b0, 1'b0, 1'b1, s, e);
    while (cyc < s + 50) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_sweep(400);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 begin
      start = 1'b0;
      abort = 1'b0;
    end
    check("start_abort_busy", longint'(busy), 0);
    repeat (200) @(negedge clk);
    check("done_count", longint'(n_done), longint'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
